isqrt_fsm: RTL
==============

Name: isqrt_fsm

Overview:
- Iterative, multi-cycle integer square-root engine.
- Serves the isqrt request/response ports of the formula FSMs; each formula instance has one isqrt_fsm per isqrt channel.
- Accepts one radicand on a single-cycle valid pulse and returns floor(sqrt(x)) on a single-cycle valid pulse after a fixed latency.
- One result bit per cycle, digit-by-digit (restoring) method; no multipliers.

Parameters:
- N_BITS, 32, radicand width; must be even and at least 4. Result width is N_BITS/2.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous, active-high reset.
- x_vld, input, 1, request pulse; x is sampled when x_vld=1 and x_rdy=1.
- x, input, N_BITS, radicand (unsigned).
- x_rdy, output, 1, high when idle and able to accept a request.
- y_vld, output, 1, single-cycle result-valid pulse.
- y, output, N_BITS/2, floor(sqrt(x)), held until the next result.

Behaviour:
- States:
  - IDLE: x_rdy=1.
  - CALC: x_rdy=0, iteration counter cnt runs 0..N_BITS/2-1.
- Reset values: state=IDLE, y_vld=0, y=0, cnt=0, internal remainder, root and operand registers all 0.
- Reset has priority over every other event, including mid-CALC; an in-flight computation is dropped and no y_vld is produced.
- Accept: at an edge with state=IDLE and x_vld=1:
  - operand register <- x, rem <- 0, root <- 0, cnt <- 0;
  - state <- CALC.
- Iteration: each edge in CALC does the following:
  - rem_ext = {rem, opnd[N_BITS-1:N_BITS-2]};
  - trial = rem_ext - {root, 2'b01};
  - if trial is non-negative (no borrow): rem <- trial and root <- {root, 1'b1}; otherwise rem <- rem_ext and root <- {root, 1'b0};
  - opnd <- opnd << 2; cnt <- cnt + 1.
- Width rules:
  - rem is N_BITS/2+2 bits.
  - trial is computed at N_BITS/2+3 bits; its MSB is the borrow flag.
  - root is N_BITS/2 bits.
  - All arithmetic is unsigned with no truncation of significant bits.
- Completion: on the edge where cnt = N_BITS/2-1, the final root bit is computed and written directly to y; y_vld <- 1, state <- IDLE.
- Latency: x_vld accepted at edge t gives y_vld=1 during the cycle after edge t+N_BITS/2 (16 edges for N_BITS=32).
- y_vld is cleared by default every edge, so it is exactly one cycle wide.
- x_rdy:
  - Combinational, equal to (state==IDLE).
  - It is high in the same cycle y_vld is high, so a new request can be accepted at the edge that ends the y_vld cycle. Back-to-back throughput is one result per N_BITS/2+1 cycles.
- x_vld while in CALC: the request is ignored with no side effect. The requester must honour x_rdy; the formula FSMs issue requests only after the previous result.
- y holds its last value while idle and is updated only at completion.
- Boundaries:
  - x=0 gives y=0.
  - x=2^N_BITS-1 gives y=2^(N_BITS/2)-1 with no overflow of rem, by construction of the widths.
  - x equal to a perfect square gives the exact root; perfect square minus 1 gives root-1.

Decomposition:
- Package isqrt_pkg contains:
  - the state enum typedef (IDLE, CALC);
  - the localparam for root width;
  - the localparam for rem width;
  - the localparam for iteration count.
- One natural combinational sub-module, isqrt_step:
  - inputs: rem, root, top two operand bits;
  - outputs: next rem, next root bit.
- isqrt_step is reused if a pipelined variant is built later.

Test Plan:
- Reset, then x_vld=1 with x=0 -> y_vld exactly 16 cycles later, y=0; x_rdy=1 in that same cycle.
- x=1, 15, 16, 1000000 (sequential requests, each after the previous y_vld) -> y=1, 3, 4, 1000 respectively.
- x=32'hFFFF_FFFF -> y=16'hFFFF; x=32'hFFFE_0001 -> 16'hFFFF; x=32'hFFFE_0000 -> 16'hFFFE.
- x=49 accepted, then x_vld=1 with x=100 on cycle 5 of CALC -> only one y_vld, with y=7; a subsequent x=100 accepted once x_rdy=1 -> y=10.
- Back-to-back: x=81, then x=144 pulsed at the edge ending the first y_vld cycle -> y=9, then y=12, 17 cycles apart.
- x=10000 accepted, rst pulsed at cycle 8 of CALC -> y_vld never asserts, y=0, x_rdy=1 the cycle after rst; next x=4 -> y=2.

Source files
------------

// File: rtl/isqrt_pkg.sv
// -----------------------------------------------------------------------------
// isqrt_pkg
// Shared types and sizing for the iterative integer square-root engine.
//   state_t      : FSM states of isqrt_fsm (IDLE accepts, CALC iterates)
//   N_BITS_DEF   : default radicand width
//   ROOT_W       : root width for the default radicand width
//   REM_W        : remainder width for the default radicand width
//   N_ITER       : iterations (one root bit each) for the default width
//   *_f functions: the same sizing rules for any even radicand width
// -----------------------------------------------------------------------------
package isqrt_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int N_BITS_DEF = 32;
  localparam int ROOT_W     = N_BITS_DEF / 2;
  localparam int REM_W      = ROOT_W + 2;
  localparam int N_ITER     = ROOT_W;

  function automatic int root_w_f(input int n_bits);
    return n_bits / 2;
  endfunction

  // Remainder never exceeds 2*root, so two bits above the root suffice.
  function automatic int rem_w_f(input int n_bits);
    return (n_bits / 2) + 2;
  endfunction

  function automatic int n_iter_f(input int n_bits);
    return n_bits / 2;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// -----------------------------------------------------------------------------
// isqrt_step
// One restoring digit step of the square root: brings down the next two
// radicand bits, tries to subtract {root, 01} and keeps the result when it
// does not borrow.
//   rem      : current partial remainder (RW+2 bits)
//   root     : root bits found so far (RW bits)
//   opnd_top : next two radicand bits
//   rem_nxt  : remainder after this step
//   root_bit : root bit produced by this step
// -----------------------------------------------------------------------------
module isqrt_step
  import isqrt_pkg::*;
#(
  parameter int RW = ROOT_W
) (
  input  logic [RW+1:0] rem,
  input  logic [RW-1:0] root,
  input  logic [1:0]    opnd_top,
  output logic [RW+1:0] rem_nxt,
  output logic          root_bit
);

  logic [RW+3:0] rem_ext_s;
  logic [RW+2:0] trial_s;
  logic          borrow_s;

  // Trial subtraction and restore decision.
  always_comb begin
    rem_ext_s = {rem, opnd_top};
    trial_s   = rem_ext_s[RW+2:0] - {1'b0, root, 2'b01};
    // A set top bit of rem_ext means the true difference is positive
    // regardless of the narrowed trial; it cannot occur in range but the
    // decision stays arithmetically exact.
    borrow_s  = trial_s[RW+2] & ~rem_ext_s[RW+3];
    if (borrow_s) begin
      rem_nxt  = rem_ext_s[RW+1:0];
      root_bit = 1'b0;
    end else begin
      rem_nxt  = trial_s[RW+1:0];
      root_bit = 1'b1;
    end
  end

endmodule

// File: rtl/isqrt_fsm.sv
// -----------------------------------------------------------------------------
// isqrt_fsm
// Iterative integer square root, one result bit per cycle. A request taken
// while idle returns floor(sqrt(x)) on a one-cycle y_vld pulse N_BITS/2
// edges after acceptance.
//   clk   : clock
//   rst   : synchronous active-high reset, drops any computation in flight
//   x_vld : request pulse, taken when x_rdy is high
//   x     : unsigned radicand
//   x_rdy : engine idle and able to accept (combinational from state)
//   y_vld : one-cycle result pulse
//   y     : floor(sqrt(x)), held until the next result
// -----------------------------------------------------------------------------
module isqrt_fsm
  import isqrt_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                x_vld,
  input  logic [N_BITS-1:0]   x,
  output logic                x_rdy,
  output logic                y_vld,
  output logic [N_BITS/2-1:0] y
);

  localparam int RT_W  = root_w_f(N_BITS);
  localparam int RM_W  = rem_w_f(N_BITS);
  localparam int ITERS = n_iter_f(N_BITS);
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [N_BITS-1:0] opnd_r;
  logic [RM_W-1:0]   rem_r;
  logic [RT_W-1:0]   root_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [RT_W-1:0]   y_r;
  logic              y_vld_r;
  logic [RM_W-1:0]   rem_nxt_s;
  logic              root_bit_s;
  logic              last_s;

  isqrt_step #(
    .RW (RT_W)
  ) u_step (
    .rem      (rem_r),
    .root     (root_r),
    .opnd_top (opnd_r[N_BITS-1:N_BITS-2]),
    .rem_nxt  (rem_nxt_s),
    .root_bit (root_bit_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and ready indication.
  always_comb begin
    state_nxt_s = state_r;
    x_rdy       = 1'b0;
    last_s      = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        x_rdy = 1'b1;
        if (x_vld) begin
          state_nxt_s = CALC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath: operand load, per-cycle digit step and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd_r  <= {N_BITS{1'b0}};
      rem_r   <= {RM_W{1'b0}};
      root_r  <= {RT_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      y_r     <= {RT_W{1'b0}};
      y_vld_r <= 1'b0;
    end else begin
      y_vld_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (x_vld) begin
            opnd_r <= x;
            rem_r  <= {RM_W{1'b0}};
            root_r <= {RT_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
          end
        end
        CALC: begin
          rem_r  <= rem_nxt_s;
          root_r <= {root_r[RT_W-2:0], root_bit_s};
          opnd_r <= {opnd_r[N_BITS-3:0], 2'b00};
          cnt_r  <= cnt_r + CNT_W'(1);
          // The last bit goes straight to y rather than via root_r.
          if (last_s) begin
            y_r     <= {root_r[RT_W-2:0], root_bit_s};
            y_vld_r <= 1'b1;
          end
        end
        default: begin
          y_vld_r <= 1'b0;
        end
      endcase
    end
  end

  assign y_vld = y_vld_r;
  assign y     = y_r;

endmodule
